// File: rtl/game_io_hub.sv
// game_io_hub
// Memory-mapped I/O hub between the processor data port and the game logic.
// Loads and stores above data-memory space reach the player input, position,
// collision and power-up registers. Every player is tested for sprite overlap
// against every valid power-up. An overlap consumes the power-up and starts a
// staged duration timer, which is per player (private) or global (shared).
// All state changes on the falling clock edge.
//
// Ports
//   clock, reset     system clock; asynchronous active-high reset
//   address_dmem     processor data address (17 bits)
//   data, wren       processor store data / store enable
//   q_dmem           data-memory read data
//   dir_in, coll_in  per player p, nibble [4p+3:4p] = {left,down,right,up}
//   dmem_wren        wren qualified to data-memory space (combinational)
//   proc_data_in     registered load data back to the processor
//   player_x/_y      packed player positions, 32 bits each
//   powerup_x/_y     packed power-up positions, 32 bits each
//   powerup_valid    power-up present on the board
//   effect_active    bit p*NUM_POWERUPS+k = effect k active for player p
//   effect_stage     per power-up stage of its most recent grant (0 = idle)
module game_io_hub #(
    parameter int                      NUM_PLAYERS     = 2,
    parameter int                      NUM_POWERUPS    = 2,
    parameter int                      SPRITE_W        = 24,
    parameter int                      SPRITE_H        = 24,
    parameter int                      TICKS_PER_STAGE = 100000000,
    parameter int                      NUM_STAGES      = 7,
    parameter logic [NUM_POWERUPS-1:0] SHARED_MASK     = '0
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [16:0]                          address_dmem,
    input  logic [31:0]                          data,
    input  logic                                 wren,
    input  logic [31:0]                          q_dmem,
    input  logic [4*NUM_PLAYERS-1:0]             dir_in,
    input  logic [4*NUM_PLAYERS-1:0]             coll_in,
    output logic                                 dmem_wren,
    output logic [31:0]                          proc_data_in,
    output logic [32*NUM_PLAYERS-1:0]            player_x,
    output logic [32*NUM_PLAYERS-1:0]            player_y,
    output logic [32*NUM_POWERUPS-1:0]           powerup_x,
    output logic [32*NUM_POWERUPS-1:0]           powerup_y,
    output logic [NUM_POWERUPS-1:0]              powerup_valid,
    output logic [NUM_PLAYERS*NUM_POWERUPS-1:0]  effect_active,
    output logic [8*NUM_POWERUPS-1:0]            effect_stage
);

    localparam int TW = $clog2(TICKS_PER_STAGE);
    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_STAGE - 1);
    localparam logic [7:0]    STAGE_LAST = 8'(NUM_STAGES);

    logic [31:0]   px_q [NUM_PLAYERS];
    logic [31:0]   px_d [NUM_PLAYERS];
    logic [31:0]   py_q [NUM_PLAYERS];
    logic [31:0]   py_d [NUM_PLAYERS];
    logic [31:0]   ux_q [NUM_POWERUPS];
    logic [31:0]   ux_d [NUM_POWERUPS];
    logic [31:0]   uy_q [NUM_POWERUPS];
    logic [31:0]   uy_d [NUM_POWERUPS];
    logic [NUM_POWERUPS-1:0] valid_q, valid_d;
    // A shared power-up keeps its single timer in the player-0 slot.
    logic [7:0]    stage_q [NUM_PLAYERS][NUM_POWERUPS];
    logic [7:0]    stage_d [NUM_PLAYERS][NUM_POWERUPS];
    logic [TW-1:0] tick_q  [NUM_PLAYERS][NUM_POWERUPS];
    logic [TW-1:0] tick_d  [NUM_PLAYERS][NUM_POWERUPS];
    logic [PW-1:0] last_q  [NUM_POWERUPS];
    logic [PW-1:0] last_d  [NUM_POWERUPS];
    logic [31:0]   proc_q, rd_data;

    logic          ovl   [NUM_PLAYERS][NUM_POWERUPS];
    logic          grant [NUM_PLAYERS][NUM_POWERUPS];
    logic [NUM_POWERUPS-1:0] hit;
    logic [PW-1:0] win   [NUM_POWERUPS];

    assign dmem_wren    = wren && (address_dmem < 17'd4096);
    assign proc_data_in = proc_q;

    // Overlap in 33 bits so position + sprite size never wraps.
    // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        hit = '0;
        for (int k = 0; k < NUM_POWERUPS; k++) begin
            win[k] = '0;
            for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
                ovl[p][k] = ({1'b0, px_q[p]} <= {1'b0, ux_q[k]} + 33'(SPRITE_W)) &&
                            ({1'b0, ux_q[k]} <= {1'b0, px_q[p]} + 33'(SPRITE_W)) &&
                            ({1'b0, py_q[p]} <= {1'b0, uy_q[k]} + 33'(SPRITE_H)) &&
                            ({1'b0, uy_q[k]} <= {1'b0, py_q[p]} + 33'(SPRITE_H));
                // Descending scan leaves the lowest overlapping index as winner.
                if (ovl[p][k]) begin
                    hit[k] = 1'b1;
                    win[k] = PW'(p);
                end
            end
        end
    end

    always_comb begin
        px_d    = px_q;
        py_d    = py_q;
        ux_d    = ux_q;
        uy_d    = uy_q;
        valid_d = valid_q;
        stage_d = stage_q;
        tick_d  = tick_q;
        last_d  = last_q;
        for (int k = 0; k < NUM_POWERUPS; k++) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                grant[p][k] = valid_q[k] && hit[k] &&
                              (SHARED_MASK[k] ? (p == 0) : (win[k] == PW'(p)));
                // A grant restarts the timer and takes priority over expiry.
                if (grant[p][k]) begin
                    stage_d[p][k] = 8'd1;
                    tick_d[p][k]  = '0;
                end else if (stage_q[p][k] != 8'd0) begin
                    if (tick_q[p][k] == TICK_LAST) begin
                        tick_d[p][k]  = '0;
                        stage_d[p][k] = (stage_q[p][k] == STAGE_LAST) ? 8'd0
                                                                      : stage_q[p][k] + 8'd1;
                    end else begin
                        tick_d[p][k] = tick_q[p][k] + 1'b1;
                    end
                end
            end
            if (valid_q[k] && hit[k]) begin
                valid_d[k] = 1'b0;
                if (!SHARED_MASK[k]) last_d[k] = win[k];
            end
        end
        // Stores land after the grant so a respawn write wins over consumption.
        if (wren) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (address_dmem == 17'(4200 + 3*p)) px_d[p] = data;
                if (address_dmem == 17'(4201 + 3*p)) py_d[p] = data;
            end
            for (int k = 0; k < NUM_POWERUPS; k++) begin
                if (address_dmem == 17'(4500 + 2*k)) ux_d[k] = data;
                if (address_dmem == 17'(4501 + 2*k)) begin
                    uy_d[k]    = data;
                    valid_d[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (address_dmem < 17'd4096) rd_data = q_dmem;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (address_dmem == 17'(4100 + p)) begin
                case (dir_in[4*p +: 4])
                    4'b0001: rd_data = 32'd1;
                    4'b0010: rd_data = 32'd2;
                    4'b0100: rd_data = 32'd3;
                    4'b1000: rd_data = 32'd4;
                    default: rd_data = 32'd0;
                endcase
            end
            if (address_dmem == 17'(4200 + 3*p)) rd_data = px_q[p];
            if (address_dmem == 17'(4201 + 3*p)) rd_data = py_q[p];
            if (address_dmem == 17'(4202 + 3*p))
                rd_data = 32'(effect_active[p*NUM_POWERUPS +: NUM_POWERUPS]);
            for (int d = 0; d < 4; d++)
                if (address_dmem == 17'(4300 + 4*p + d)) rd_data = 32'(coll_in[4*p + d]);
        end
        for (int k = 0; k < NUM_POWERUPS; k++) begin
            if (address_dmem == 17'(4500 + 2*k)) rd_data = ux_q[k];
            if (address_dmem == 17'(4501 + 2*k)) rd_data = uy_q[k];
        end
    end

    always_comb begin
        effect_stage = '0;
        for (int k = 0; k < NUM_POWERUPS; k++) begin
            effect_stage[8*k +: 8] = stage_q[0][k];
            for (int p = 1; p < NUM_PLAYERS; p++)
                if (last_q[k] == PW'(p)) effect_stage[8*k +: 8] = stage_q[p][k];
        end
    end

    always_comb begin
        effect_active = '0;
        player_x      = '0;
        player_y      = '0;
        powerup_x     = '0;
        powerup_y     = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            player_x[32*p +: 32] = px_q[p];
            player_y[32*p +: 32] = py_q[p];
            for (int k = 0; k < NUM_POWERUPS; k++)
                effect_active[p*NUM_POWERUPS + k] =
                    SHARED_MASK[k] ? (stage_q[0][k] != 8'd0) : (stage_q[p][k] != 8'd0);
        end
        for (int k = 0; k < NUM_POWERUPS; k++) begin
            powerup_x[32*k +: 32] = ux_q[k];
            powerup_y[32*k +: 32] = uy_q[k];
        end
    end
    assign powerup_valid = valid_q;

    // NOTE: the hub state updates on the falling edge so load data settles half a cycle before the processor's rising-edge capture.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                px_q[p] <= 32'(260 + 100*p);
                py_q[p] <= 32'd240;
                for (int k = 0; k < NUM_POWERUPS; k++) begin
                    stage_q[p][k] <= '0;
                    tick_q[p][k]  <= '0;
                end
            end
            for (int k = 0; k < NUM_POWERUPS; k++) begin
                ux_q[k]   <= 32'(300 + 100*k);
                uy_q[k]   <= 32'(300 + 100*k);
                last_q[k] <= '0;
            end
            valid_q <= '1;
            proc_q  <= '0;
        end else begin
            px_q    <= px_d;
            py_q    <= py_d;
            ux_q    <= ux_d;
            uy_q    <= uy_d;
            valid_q <= valid_d;
            stage_q <= stage_d;
            tick_q  <= tick_d;
            last_q  <= last_d;
            if (!wren) proc_q <= rd_data;
        end
    end

endmodule
